// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and stalls on MemReady.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXE   = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_IEXE   = 4'd10,
    S_SEXE   = 4'd11,
    S_IWB    = 4'd12,
    S_JMP    = 4'd13
  } state_t;

  state_t state;

  assign State = state;

  // State sequencing; IllegalOp pulses the cycle after an undefined opcode decodes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      IllegalOp <= 1'b0;
    end else begin
      IllegalOp <= 1'b0;
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: if (MemReady) state <= S_DECODE;
        S_DECODE: begin
          case (Opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_REXE;
            OP_BEQ:       state <= S_BEQ;
            OP_ADDI:      state <= S_IEXE;
            OP_SLTI:      state <= S_SEXE;
            OP_J:         state <= S_JMP;
            default: begin
              state     <= S_FETCH;
              IllegalOp <= 1'b1;
            end
          endcase
        end
        S_MEMADR: state <= (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (MemReady) state <= S_MEMWB;
        S_MEMWR:  if (MemReady) state <= S_FETCH;
        S_REXE:   state <= S_RWB;
        S_IEXE,
        S_SEXE:   state <= S_IWB;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from the current state
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    PCSource    = 2'b00;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUop   = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUop   = 2'b01;
      end
      S_MEMADR, S_IEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUop   = 2'b01;
      end
      S_SEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUop   = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXE: begin
        ALUSrcA = 1'b1;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b11;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_IWB: begin
        RegWrite = 1'b1;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

endmodule
